chan_mask_packer: RTL and testbench

CHAN_MASK_PACKER -- requirements
Module: chan_mask_packer

---
 rtl/chan_mask_packer.sv | 136 +++++++++++++
 tb/tb_chan_mask_packer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chan_mask_packer.sv
// Channel-mask packer: forwards only the enabled channels of a channel-interleaved stream.
// Optional framing-error counter enabled by defining CHAN_MASK_PACKER_ERR_CNT_EN.
module chan_mask_packer #(
   parameter int NUM_CHAN     = 128,
   parameter int WIDTH        = 32,
   parameter int SR_MASK_BASE = 128
) (
   input  logic                        ce_clk,
   input  logic                        ce_rst,
   input  logic                        set_stb,
   input  logic [7:0]                  set_addr,
   input  logic [31:0]                 set_data,
   input  logic [WIDTH-1:0]            i_tdata,
   input  logic                        i_tlast,
   input  logic                        i_tvalid,
   output logic                        i_tready,
   output logic [WIDTH-1:0]            o_tdata,
   output logic [$clog2(NUM_CHAN)-1:0] o_tuser,
   output logic                        o_tlast,
   output logic                        o_tvalid,
   input  logic                        o_tready,
   output logic [15:0]                 err_cnt
);

   localparam int NW = NUM_CHAN / 32;
   localparam int CW = $clog2(NUM_CHAN);
   localparam logic [CW-1:0] LAST_CHAN   = CW'(NUM_CHAN - 1);
   localparam logic [7:0]    MASK_LO     = 8'(SR_MASK_BASE);
   localparam logic [7:0]    COMMIT_ADDR = 8'(SR_MASK_BASE + NW);

   function automatic logic [CW-1:0] high_bit(input logic [NUM_CHAN-1:0] m);
      logic [CW-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_CHAN; i++)
         if (m[i]) r = CW'(i);
      return r;
   endfunction

   logic [CW-1:0]       chan;
   logic [NUM_CHAN-1:0] shadow;
   logic [NUM_CHAN-1:0] active;
   logic [CW-1:0]       last_idx;
   logic                commit_pending;
   logic                accept, at_last, frame_end, apply_commit;
   logic                commit_wr, mask_wr, sel_p0;
   logic [7:0]          word_idx;
   logic                vld_p1;
   logic [WIDTH-1:0]    data_p1;
   logic [CW-1:0]       user_p1;
   logic                last_p1;

   assign i_tready     = !vld_p1 | o_tready;
   assign accept       = i_tvalid & i_tready;
   assign at_last      = (chan == LAST_CHAN);
   assign frame_end    = accept & (i_tlast | at_last);
   // Idle at a frame boundary also counts as a safe point to swap masks.
   assign apply_commit = commit_pending & (frame_end | ((chan == '0) & !accept));
   assign word_idx     = set_addr - MASK_LO;
   assign mask_wr      = set_stb & (set_addr >= MASK_LO) & (set_addr < COMMIT_ADDR);
   assign commit_wr    = set_stb & (set_addr == COMMIT_ADDR);
   assign sel_p0       = accept & active[chan];

   always_ff @(posedge ce_clk) begin
      if (ce_rst) begin
         chan           <= '0;
         shadow         <= '1;
         active         <= '1;
         last_idx       <= LAST_CHAN;
         commit_pending <= 1'b0;
      end else begin
         if (frame_end)
            chan <= '0;
         else if (accept)
            chan <= chan + 1'b1;

         for (int k = 0; k < NW; k++)
            if (mask_wr && word_idx == 8'(k))
               shadow[32*k +: 32] <= set_data;

         if (commit_wr)
            commit_pending <= 1'b1;
         else if (apply_commit)
            commit_pending <= 1'b0;

         if (apply_commit) begin
            active   <= shadow;
            last_idx <= high_bit(shadow);
         end
      end
   end

   // p0 -> p1: one-entry output register
   always_ff @(posedge ce_clk) begin
      if (ce_rst) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         user_p1 <= '0;
         last_p1 <= 1'b0;
      end else if (sel_p0) begin
         vld_p1  <= 1'b1;
         data_p1 <= i_tdata;
         user_p1 <= chan;
         last_p1 <= (chan == last_idx);
      end else if (o_tready) begin
         vld_p1  <= 1'b0;
      end
   end

   assign o_tvalid = vld_p1;
   assign o_tdata  = data_p1;
   assign o_tuser  = user_p1;
   assign o_tlast  = last_p1;

`ifdef CHAN_MASK_PACKER_ERR_CNT_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic        frame_err;
   logic [15:0] err_q;

   assign frame_err = accept & (i_tlast ^ at_last);

   always_ff @(posedge ce_clk) begin
      if (ce_rst)
         err_q <= '0;
      else if (frame_err)
         err_q <= sat_inc(err_q);
   end

   assign err_cnt = err_q;
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_chan_mask_packer.sv
// Scoreboard bench for chan_mask_packer: directed frames push expectations, a monitor checks transfers.
module tb_chan_mask_packer;
   localparam int NC = 128;
   localparam int W  = 32;
   localparam int CW = 7;

   logic          ce_clk = 1'b0;
   logic          ce_rst = 1'b1;
   logic          set_stb = 1'b0;
   logic [7:0]    set_addr = '0;
   logic [31:0]   set_data = '0;
   logic [W-1:0]  i_tdata = '0;
   logic          i_tlast = 1'b0;
   logic          i_tvalid = 1'b0;
   logic          i_tready;
   logic [W-1:0]  o_tdata;
   logic [CW-1:0] o_tuser;
   logic          o_tlast;
   logic          o_tvalid;
   logic          o_tready = 1'b1;
   logic [15:0]   err_cnt;

   chan_mask_packer #(.NUM_CHAN(NC), .WIDTH(W), .SR_MASK_BASE(128)) dut (
      .ce_clk(ce_clk), .ce_rst(ce_rst),
      .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
      .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
      .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
      .o_tready(o_tready), .err_cnt(err_cnt)
   );

   always #5 ce_clk = ~ce_clk;

   typedef struct packed {
      logic [W-1:0]  d;
      logic [CW-1:0] u;
      logic          l;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   stalls = 0;
   int   rdy_mode = 0;

`ifdef CHAN_MASK_PACKER_ERR_CNT_EN
   localparam logic [15:0] ERR1 = 16'd1;
   localparam logic [15:0] ERR2 = 16'd2;
`else
   localparam logic [15:0] ERR1 = 16'd0;
   localparam logic [15:0] ERR2 = 16'd0;
`endif

   // o_tready: always high (mode 0) or high one cycle in three (mode 1)
   initial begin
      int c;
      c = 0;
      forever begin
         @(posedge ce_clk);
         #1;
         c++;
         o_tready = (rdy_mode == 0) ? 1'b1 : ((c % 3) == 0);
      end
   end

   // Monitor: pops and compares on every transfer, checks hold while stalled
   initial begin
      exp_t e, pv;
      bit   ps;
      ps = 1'b0;
      pv = '0;
      forever begin
         @(negedge ce_clk);
         if (ce_rst) begin
            ps = 1'b0;
         end else begin
            if (ps) begin
               checks++;
               if (!o_tvalid || o_tdata !== pv.d || o_tuser !== pv.u || o_tlast !== pv.l) begin
                  failures++;
                  $display("FAIL stall_hold actual vld=%0b d=%0h u=%0d l=%0b required vld=1 d=%0h u=%0d l=%0b",
                           o_tvalid, o_tdata, o_tuser, o_tlast, pv.d, pv.u, pv.l);
               end
            end
            if (o_tvalid && o_tready) begin
               checks++;
               if (q.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_output actual d=%0h u=%0d l=%0b required none",
                           o_tdata, o_tuser, o_tlast);
               end else begin
                  e = q.pop_front();
                  if (o_tdata !== e.d || o_tuser !== e.u || o_tlast !== e.l) begin
                     failures++;
                     $display("FAIL out_beat actual d=%0h u=%0d l=%0b required d=%0h u=%0d l=%0b",
                              o_tdata, o_tuser, o_tlast, e.d, e.u, e.l);
                  end
               end
            end
            ps = o_tvalid && !o_tready;
            pv = {o_tdata, o_tuser, o_tlast};
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge ce_clk);
         #1;
      end
   endtask

   task automatic set_wr(input logic [7:0] a, input logic [31:0] d);
      set_stb = 1'b1; set_addr = a; set_data = d;
      @(posedge ce_clk);
      #1;
      set_stb = 1'b0;
   endtask

   task automatic beat(input logic [W-1:0] d, input bit last);
      bit acc;
      int w;
      i_tvalid = 1'b1; i_tdata = d; i_tlast = last;
      w = 0;
      do begin
         @(negedge ce_clk);
         acc = i_tready;
         if (!acc) stalls++;
         @(posedge ce_clk);
         #1;
         w++;
      end while (!acc && w < 200);
      i_tvalid = 1'b0; i_tlast = 1'b0;
      if (!acc) begin
         checks++; failures++;
         $display("FAIL beat_timeout actual=not_accepted required=accepted d=%0h", d);
      end
   endtask

   // n beats starting at chan 0; expectations come from the mask the test says is active
   task automatic frame(input int base, input logic [NC-1:0] mask, input int hi,
                        input int n, input int tlast_at, input int commit_at);
      for (int ch = 0; ch < n; ch++) begin
         if (mask[ch]) q.push_back(exp_t'{d: W'(base + ch), u: CW'(ch), l: (ch == hi)});
         if (ch == commit_at) begin
            set_stb = 1'b1; set_addr = 8'd132; set_data = 32'hDEAD_BEEF;
         end
         beat(W'(base + ch), ch == tlast_at);
         set_stb = 1'b0;
      end
   endtask

   task automatic drain(input string name);
      int w;
      w = 0;
      while (q.size() != 0 && w < 2000) begin
         @(posedge ce_clk);
         w++;
      end
      #1;
      idle(3);
      chk(name, q.size(), 0);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_o_tvalid"}, o_tvalid, 0);
      chk({tag, "_o_tdata"},  o_tdata, 0);
      chk({tag, "_o_tuser"},  o_tuser, 0);
      chk({tag, "_o_tlast"},  o_tlast, 0);
      chk({tag, "_err_cnt"},  err_cnt, 0);
      chk({tag, "_i_tready"}, i_tready, 1);
   endtask

   initial begin
      repeat (2) @(posedge ce_clk);
      @(negedge ce_clk);
      reset_checks("rst");
      @(posedge ce_clk);
      #1;
      ce_rst = 1'b0;

      // Reset mask: every channel, last at 127
      frame(0,   '1, 127, 128, 127, -1);
      frame(128, '1, 127, 128, 127, -1);
      drain("drain_full");

      // Mask 0x5 in word 0: channels 0 and 2, last on 2
      set_wr(8'd128, 32'h0000_0005);
      set_wr(8'd129, 32'h0);
      set_wr(8'd130, 32'h0);
      set_wr(8'd131, 32'h0);
      set_wr(8'd132, 32'h0);
      idle(3);
      frame(1000, 128'h5, 2, 128, 127, -1);
      frame(1200, 128'h5, 2, 128, 127, -1);
      drain("drain_mask5");

      // Commit at chan=60: old mask for this frame, channel 32 only afterwards
      set_wr(8'd128, 32'h0);
      set_wr(8'd129, 32'h1);
      frame(2000, 128'h5, 2, 128, 127, 60);
      frame(3000, 128'h1_0000_0000, 32, 128, 127, -1);
      drain("drain_midcommit");

      // Framing errors: early tlast at 99, then a frame missing tlast
      for (int k = 0; k < 4; k++) set_wr(8'(128 + k), 32'hFFFF_FFFF);
      set_wr(8'd132, 32'h0);
      idle(3);
      frame(4000, '1, 127, 100, 99, -1);
      frame(5000, '1, 127, 128, 127, -1);
      drain("drain_short");
      chk("err_cnt_short", err_cnt, ERR1);
      frame(6000, '1, 127, 128, -1, -1);
      frame(7000, '1, 127, 128, 127, -1);
      drain("drain_notlast");
      chk("err_cnt_notlast", err_cnt, ERR2);

      // Backpressure: o_tready high one cycle in three
      rdy_mode = 1;
      frame(8000, '1, 127, 128, 127, -1);
      drain("drain_bp");
      rdy_mode = 0;
      idle(2);

      // All-zero mask: nothing out, input never stalled
      for (int k = 0; k < 4; k++) set_wr(8'(128 + k), 32'h0);
      set_wr(8'd132, 32'h0);
      idle(3);
      stalls = 0;
      for (int f = 0; f < 3; f++) frame(f * 128, '0, 0, 128, 127, -1);
      chk("zero_mask_stalls", stalls, 0);
      chk("zero_mask_o_tvalid", o_tvalid, 0);

      // Reset mid-frame
      frame(0, '0, 0, 50, -1, -1);
      ce_rst = 1'b1;
      @(posedge ce_clk);
      @(negedge ce_clk);
      reset_checks("midrst");
      @(posedge ce_clk);
      #1;
      ce_rst = 1'b0;
      frame(9000, '1, 127, 128, 127, -1);
      drain("drain_after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
